axi_lite_to_apb_split: RTL and testbench

AXI4-Lite slave to APB4 master bridge with a configurable AXI/APB data width ratio and a configurable number of APB slaves. It is the parametrised successor of the fixed 64-to-32 AXI-to-APB converter. Each wide AXI beat is split into `AxiDataWidth/ApbDataWidth` APB transfers, and beats whose write-strobe slice is all-zero are skipped. It sits between the peripheral crossbar and the APB peripheral cluster.

---
 rtl/axi_lite_apb_split_pkg.sv | 22 ++
 rtl/axi_lite_apb_split_decode.sv | 34 +++
 rtl/axi_lite_to_apb_split.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_lite_to_apb_split.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_apb_split_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_apb_split_pkg
// Brief    : Shared FSM state encoding and AXI response codes for the
//            AXI4-Lite to APB4 split bridge.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_apb_split_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/axi_lite_apb_split_decode.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_apb_split_decode
// Brief    : Combinational bridge-window hit check and APB slave index decode.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_apb_split_decode #(
  parameter int                      AxiAddrWidth = 32,
  parameter int                      ApbAddrWidth = 12,
  parameter int                      NoApbSlaves  = 4,
  parameter logic [AxiAddrWidth-1:0] BaseAddr     = AxiAddrWidth'(32'h0001_0000),
  localparam int                     IdxWidth     = (NoApbSlaves > 1) ? $clog2(NoApbSlaves) : 1
) (
  input  logic [AxiAddrWidth-1:0] addr,
  output logic                    hit,
  output logic [IdxWidth-1:0]     idx
);

  localparam int c_SEL_BITS = $clog2(NoApbSlaves);
  localparam int c_WIN_BITS = ApbAddrWidth + c_SEL_BITS;

  // Window is naturally aligned, so comparing the bits above it is sufficient.
  assign hit = ((addr >> c_WIN_BITS) == (BaseAddr >> c_WIN_BITS));

  generate
    if (NoApbSlaves > 1) begin : g_multi
      assign idx = addr[ApbAddrWidth +: c_SEL_BITS];
    end else begin : g_single
      assign idx = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_lite_to_apb_split.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_to_apb_split
// Brief    : AXI4-Lite slave to APB4 master; splits each wide beat into
//            narrow APB transfers. Optional watchdog: AXI_LITE_APB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_to_apb_split
  import axi_lite_apb_split_pkg::*;
#(
  parameter int                      AxiAddrWidth  = 32,
  parameter int                      AxiDataWidth  = 64,
  parameter int                      ApbAddrWidth  = 12,
  parameter int                      ApbDataWidth  = 32,
  parameter int                      NoApbSlaves   = 4,
  parameter logic [AxiAddrWidth-1:0] BaseAddr      = AxiAddrWidth'(32'h0001_0000),
  parameter int                      TimeoutCycles = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [AxiAddrWidth-1:0]             aw_addr_i,
  input  logic                                aw_valid_i,
  output logic                                aw_ready_o,
  input  logic [AxiDataWidth-1:0]             w_data_i,
  input  logic [AxiDataWidth/8-1:0]           w_strb_i,
  input  logic                                w_valid_i,
  output logic                                w_ready_o,
  output logic [1:0]                          b_resp_o,
  output logic                                b_valid_o,
  input  logic                                b_ready_i,
  input  logic [AxiAddrWidth-1:0]             ar_addr_i,
  input  logic                                ar_valid_i,
  output logic                                ar_ready_o,
  output logic [AxiDataWidth-1:0]             r_data_o,
  output logic [1:0]                          r_resp_o,
  output logic                                r_valid_o,
  input  logic                                r_ready_i,
  output logic [ApbAddrWidth-1:0]             paddr_o,
  output logic                                pwrite_o,
  output logic [ApbDataWidth-1:0]             pwdata_o,
  output logic [ApbDataWidth/8-1:0]           pstrb_o,
  output logic [NoApbSlaves-1:0]              psel_o,
  output logic                                penable_o,
  input  logic [NoApbSlaves*ApbDataWidth-1:0] prdata_i,
  input  logic [NoApbSlaves-1:0]              pready_i,
  input  logic [NoApbSlaves-1:0]              pslverr_i
);

  localparam int c_RATIO    = AxiDataWidth / ApbDataWidth;
  localparam int c_AXI_STRB = AxiDataWidth / 8;
  localparam int c_APB_STRB = ApbDataWidth / 8;
  localparam int c_BEAT_W   = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
  localparam int c_IDX_W    = (NoApbSlaves > 1) ? $clog2(NoApbSlaves) : 1;

  state_e                    r_state, w_state_nxt;
  logic                      r_ar_ready, r_aw_ready, r_last_write;
  logic [ApbAddrWidth-1:0]   r_addr;
  logic [c_IDX_W-1:0]        r_idx;
  logic                      r_write;
  logic [AxiDataWidth-1:0]   r_wdata, r_rdata;
  logic [c_AXI_STRB-1:0]     r_strb;
  logic [c_RATIO-1:0]        r_mask;
  logic [c_BEAT_W-1:0]       r_beat;
  logic [1:0]                r_resp;

  logic                      w_hs_rd, w_hs_wr, w_hs, w_hit;
  logic                      w_grant_rd, w_grant_wr;
  logic [c_IDX_W-1:0]        w_idx;
  logic [AxiAddrWidth-1:0]   w_dec_addr;
  logic [c_RATIO-1:0]        w_hs_mask;
  logic [c_BEAT_W-1:0]       w_first_beat, w_next_beat;
  logic                      w_any_beat, w_more;
  logic                      w_sel_ready, w_sel_err, w_timeout;
  logic [ApbDataWidth-1:0]   w_sel_rdata;

  // Ready is granted a cycle ahead, so the registered address mux follows it.
  assign w_dec_addr = r_ar_ready ? ar_addr_i : aw_addr_i;
  assign w_hs_rd    = (r_state == IDLE) && r_ar_ready && ar_valid_i;
  assign w_hs_wr    = (r_state == IDLE) && r_aw_ready && aw_valid_i && w_valid_i;
  assign w_hs       = w_hs_rd || w_hs_wr;
  assign w_grant_rd = ar_valid_i && (!(aw_valid_i && w_valid_i) || r_last_write);
  assign w_grant_wr = aw_valid_i && w_valid_i && !w_grant_rd;

  axi_lite_apb_split_decode #(
    .AxiAddrWidth (AxiAddrWidth),
    .ApbAddrWidth (ApbAddrWidth),
    .NoApbSlaves  (NoApbSlaves),
    .BaseAddr     (BaseAddr)
  ) u_decode (
    .addr (w_dec_addr),
    .hit  (w_hit),
    .idx  (w_idx)
  );

  generate
    for (genvar i = 0; i < c_RATIO; i++) begin : g_mask
      assign w_hs_mask[i] = r_ar_ready || (|w_strb_i[i*c_APB_STRB +: c_APB_STRB]);
    end
  endgenerate

  // Descending scan so the lowest qualifying beat wins.
  always_comb begin
    w_first_beat = '0;
    w_any_beat   = 1'b0;
    w_next_beat  = r_beat;
    w_more       = 1'b0;
    for (int i = c_RATIO - 1; i >= 0; i--) begin
      if (w_hs_mask[i]) begin
        w_first_beat = c_BEAT_W'(i);
        w_any_beat   = 1'b1;
      end
      if (r_mask[i] && (i > int'(r_beat))) begin
        w_next_beat = c_BEAT_W'(i);
        w_more      = 1'b1;
      end
    end
  end

  assign w_sel_ready = pready_i[r_idx];
  assign w_sel_err   = pslverr_i[r_idx];
  assign w_sel_rdata = prdata_i[int'(r_idx)*ApbDataWidth +: ApbDataWidth];

`ifdef AXI_LITE_APB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TimeoutCycles + 1);
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state == SETUP) begin
      r_cnt <= '0;
    end else if (r_state == ACCESS) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == ACCESS) && !w_sel_ready &&
                     (r_cnt == c_CNT_W'(TimeoutCycles - 1));
`else
  // No watchdog: the comparison is constant false.
  assign w_timeout = (TimeoutCycles < 0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_hs) w_state_nxt = (w_hit && w_any_beat) ? SETUP : RESP;
      SETUP:  w_state_nxt = ACCESS;
      ACCESS: begin
        if (w_sel_ready)    w_state_nxt = (!w_sel_err && w_more) ? SETUP : RESP;
        else if (w_timeout) w_state_nxt = RESP;
      end
      RESP:   if (r_write ? b_ready_i : r_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ar_ready <= 1'b0;
      r_aw_ready <= 1'b0;
    end else begin
      r_ar_ready <= 1'b0;
      r_aw_ready <= 1'b0;
      if ((r_state == IDLE) && !r_ar_ready && !r_aw_ready) begin
        r_ar_ready <= w_grant_rd;
        r_aw_ready <= w_grant_wr;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_last_write <= 1'b1;
      r_addr       <= '0;
      r_idx        <= '0;
      r_write      <= 1'b0;
      r_wdata      <= '0;
      r_strb       <= '0;
      r_mask       <= '0;
      r_beat       <= '0;
      r_rdata      <= '0;
      r_resp       <= RESP_OKAY;
    end else if (w_hs) begin
      r_last_write <= w_hs_wr;
      r_addr       <= w_dec_addr[ApbAddrWidth-1:0];
      r_idx        <= w_idx;
      r_write      <= w_hs_wr;
      r_wdata      <= w_data_i;
      r_strb       <= w_strb_i;
      r_mask       <= w_hs_mask;
      r_beat       <= w_first_beat;
      r_rdata      <= '0;
      r_resp       <= w_hit ? RESP_OKAY : RESP_DECERR;
    end else if (r_state == ACCESS) begin
      if (w_sel_ready) begin
        if (!r_write) r_rdata[int'(r_beat)*ApbDataWidth +: ApbDataWidth] <= w_sel_rdata;
        if (w_sel_err)   r_resp <= RESP_SLVERR;
        else if (w_more) r_beat <= w_next_beat;
      end else if (w_timeout) begin
        r_resp <= RESP_SLVERR;
      end
    end
  end

  assign aw_ready_o = r_aw_ready;
  assign w_ready_o  = r_aw_ready;
  assign ar_ready_o = r_ar_ready;
  assign r_valid_o  = (r_state == RESP) && !r_write;
  assign b_valid_o  = (r_state == RESP) && r_write;
  assign r_data_o   = r_rdata;
  assign r_resp_o   = r_resp;
  assign b_resp_o   = r_resp;

  assign psel_o    = ((r_state == SETUP) || (r_state == ACCESS)) ?
                     (NoApbSlaves'(1) << r_idx) : '0;
  assign penable_o = (r_state == ACCESS);
  assign paddr_o   = (r_addr & ~ApbAddrWidth'(c_AXI_STRB - 1)) +
                     ApbAddrWidth'(int'(r_beat) * c_APB_STRB);
  assign pwrite_o  = r_write;
  assign pwdata_o  = r_wdata[int'(r_beat)*ApbDataWidth +: ApbDataWidth];
  assign pstrb_o   = r_write ? r_strb[int'(r_beat)*c_APB_STRB +: c_APB_STRB] : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_to_apb_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_to_apb_split
// Brief    : Directed self-checking bench for the AXI4-Lite to APB split bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_to_apb_split;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aw_addr_i, ar_addr_i;
  logic        aw_valid_i, w_valid_i, ar_valid_i, b_ready_i, r_ready_i;
  logic [63:0] w_data_i;
  logic [7:0]  w_strb_i;
  logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic [63:0] r_data_o;
  logic [11:0] paddr_o;
  logic        pwrite_o, penable_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o, psel_o, pready_i, pslverr_i, err_mask;
  logic [127:0] prdata_i;

  logic        hold_low;
  logic [7:0]  wait_n;
  logic [7:0]  acc_cnt = 8'd0;
  logic        w_rdy;
  logic [31:0] slave_rdata;

  int n_checks = 0;
  int n_err    = 0;
  int n_apb    = 0;
  int n_en     = 0;
  logic [11:0] log_paddr [64];
  logic [3:0]  log_psel  [64];
  logic        log_pwrite[64];
  logic [3:0]  log_pstrb [64];
  logic [31:0] log_pwdata[64];

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata_for(input logic [11:0] a);
    if (a == 12'h008)      return 32'hAAAA_0001;
    else if (a == 12'h00C) return 32'hBBBB_0002;
    else                   return 32'h5A00_0000 | {20'h0, a};
  endfunction

  assign slave_rdata = rdata_for(paddr_o);
  assign prdata_i    = {4{slave_rdata}};
  assign w_rdy       = !hold_low && (acc_cnt >= wait_n);
  assign pready_i    = {4{w_rdy}};
  assign pslverr_i   = err_mask;

  always @(posedge clk) begin
    acc_cnt <= (penable_o && !w_rdy) ? acc_cnt + 8'd1 : 8'd0;
    if (penable_o) n_en <= n_en + 1;
    if (!rst && penable_o && ((psel_o & pready_i) != 4'b0)) begin
      log_paddr [n_apb % 64] <= paddr_o;
      log_psel  [n_apb % 64] <= psel_o;
      log_pwrite[n_apb % 64] <= pwrite_o;
      log_pstrb [n_apb % 64] <= pstrb_o;
      log_pwdata[n_apb % 64] <= pwdata_o;
      n_apb <= n_apb + 1;
    end
  end

  axi_lite_to_apb_split #(
    .TimeoutCycles (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .aw_addr_i  (aw_addr_i),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .w_data_i   (w_data_i),
    .w_strb_i   (w_strb_i),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .b_resp_o   (b_resp_o),
    .b_valid_o  (b_valid_o),
    .b_ready_i  (b_ready_i),
    .ar_addr_i  (ar_addr_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .paddr_o    (paddr_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .prdata_i   (prdata_i),
    .pready_i   (pready_i),
    .pslverr_i  (pslverr_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Latency counts cycles from the handshake cycle to the first valid cycle.
  task automatic do_read(input logic [31:0] addr, output logic [63:0] data,
                         output logic [1:0] resp, output int lat);
    int guard = 0;
    ar_addr_i  = addr;
    ar_valid_i = 1'b1;
    while (!ar_ready_o && guard < 100) begin @(negedge clk); guard++; end
    chk("rd_handshake_bound", 64'(guard < 100), 64'd1);
    @(negedge clk);
    ar_valid_i = 1'b0;
    lat = 1;
    while (!r_valid_o && lat < 200) begin @(negedge clk); lat++; end
    chk("rd_valid_bound", 64'(lat < 200), 64'd1);
    data = r_data_o;
    resp = r_resp_o;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, output logic [1:0] resp, output int lat);
    int guard = 0;
    aw_addr_i  = addr;
    w_data_i   = data;
    w_strb_i   = strb;
    aw_valid_i = 1'b1;
    w_valid_i  = 1'b1;
    while (!(aw_ready_o && w_ready_o) && guard < 100) begin @(negedge clk); guard++; end
    chk("wr_handshake_bound", 64'(guard < 100), 64'd1);
    @(negedge clk);
    aw_valid_i = 1'b0;
    w_valid_i  = 1'b0;
    lat = 1;
    while (!b_valid_o && lat < 200) begin @(negedge clk); lat++; end
    chk("wr_valid_bound", 64'(lat < 200), 64'd1);
    resp = b_resp_o;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  rsp;
    int          lat, base, guard, nhs, en0;
    logic [5:0]  seq;

    rst = 1'b1;
    aw_addr_i = '0; ar_addr_i = '0; w_data_i = '0; w_strb_i = '0;
    aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
    b_ready_i = 1'b1; r_ready_i = 1'b1;
    err_mask = 4'b0; hold_low = 1'b0; wait_n = 8'd0;
    repeat (3) @(negedge clk);

    chk("rst_psel",    64'(psel_o), 64'd0);
    chk("rst_penable", 64'(penable_o), 64'd0);
    chk("rst_paddr",   64'(paddr_o), 64'd0);
    chk("rst_pwdata_pstrb", 64'({pwdata_o, pstrb_o}), 64'd0);
    chk("rst_readys",  64'({aw_ready_o, w_ready_o, ar_ready_o}), 64'd0);
    chk("rst_valids",  64'({b_valid_o, r_valid_o}), 64'd0);
    chk("rst_rdata",   r_data_o, 64'd0);
    chk("rst_resps",   64'({r_resp_o, b_resp_o}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-beat read from slave 1
    base = n_apb;
    do_read(32'h0001_1008, d, rsp, lat);
    chk("rd1_data",   d, 64'hBBBB_0002_AAAA_0001);
    chk("rd1_resp",   64'(rsp), 64'd0);
    chk("rd1_lat",    64'(lat), 64'd5);
    chk("rd1_napb",   64'(n_apb - base), 64'd2);
    chk("rd1_paddr0", 64'(log_paddr[base % 64]), 64'h008);
    chk("rd1_paddr1", 64'(log_paddr[(base + 1) % 64]), 64'h00C);
    chk("rd1_psel",   64'(log_psel[base % 64]), 64'b0010);
    chk("rd1_pwrite", 64'(log_pwrite[base % 64]), 64'd0);

    // Upper-half strobe only: single beat at offset 4 to slave 3
    base = n_apb;
    do_write(32'h0001_3000, 64'h1111_2222_3333_4444, 8'hF0, rsp, lat);
    chk("wr1_napb",   64'(n_apb - base), 64'd1);
    chk("wr1_paddr",  64'(log_paddr[base % 64]), 64'h004);
    chk("wr1_psel",   64'(log_psel[base % 64]), 64'b1000);
    chk("wr1_pstrb",  64'(log_pstrb[base % 64]), 64'hF);
    chk("wr1_pwdata", 64'(log_pwdata[base % 64]), 64'h1111_2222);
    chk("wr1_pwrite", 64'(log_pwrite[base % 64]), 64'd1);
    chk("wr1_resp",   64'(rsp), 64'd0);
    chk("wr1_lat",    64'(lat), 64'd3);

    // All-zero strobe: no APB activity
    base = n_apb;
    do_write(32'h0001_3000, 64'hDEAD_BEEF_0000_0000, 8'h00, rsp, lat);
    chk("wr0_napb", 64'(n_apb - base), 64'd0);
    chk("wr0_resp", 64'(rsp), 64'd0);
    chk("wr0_lat",  64'(lat), 64'd1);

    // Decode miss
    base = n_apb;
    do_read(32'h0002_0000, d, rsp, lat);
    chk("miss_napb", 64'(n_apb - base), 64'd0);
    chk("miss_resp", 64'(rsp), 64'd3);
    chk("miss_data", d, 64'd0);
    chk("miss_lat",  64'(lat), 64'd1);

    // Slave error on beat 0 aborts beat 1
    err_mask = 4'b0001;
    base = n_apb;
    do_write(32'h0001_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, rsp, lat);
    err_mask = 4'b0000;
    chk("err_napb",  64'(n_apb - base), 64'd1);
    chk("err_resp",  64'(rsp), 64'd2);
    chk("err_lat",   64'(lat), 64'd3);

    // Two wait states per ACCESS on slave 2
    wait_n = 8'd2;
    base = n_apb;
    do_read(32'h0001_2010, d, rsp, lat);
    wait_n = 8'd0;
    chk("wait_data", d, 64'h5A00_0014_5A00_0010);
    chk("wait_lat",  64'(lat), 64'd9);
    chk("wait_resp", 64'(rsp), 64'd0);
    chk("wait_psel", 64'(log_psel[base % 64]), 64'b0100);

    // Reset asserted during ACCESS drops outputs asynchronously
    hold_low   = 1'b1;
    ar_addr_i  = 32'h0001_1000;
    ar_valid_i = 1'b1;
    guard = 0;
    while (!penable_o && guard < 100) begin @(negedge clk); guard++; end
    chk("rstmid_access_bound", 64'(guard < 100), 64'd1);
    ar_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_psel_penable", 64'({psel_o, penable_o}), 64'd0);
    chk("rstmid_paddr_pwrite", 64'({paddr_o, pwrite_o}), 64'd0);
    chk("rstmid_valids_readys",
        64'({r_valid_o, b_valid_o, ar_ready_o, aw_ready_o, w_ready_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hold_low = 1'b0;
    @(negedge clk);

    // Contention after reset: round-robin starting with read
    ar_addr_i  = 32'h0001_0000;
    aw_addr_i  = 32'h0001_1000;
    w_data_i   = 64'hCAFE_F00D_1234_5678;
    w_strb_i   = 8'hFF;
    ar_valid_i = 1'b1;
    aw_valid_i = 1'b1;
    w_valid_i  = 1'b1;
    seq = '0; nhs = 0; guard = 0;
    while (nhs < 6 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (ar_ready_o && ar_valid_i) begin
        seq = {seq[4:0], 1'b0}; nhs++;
      end else if (aw_ready_o && w_ready_o) begin
        seq = {seq[4:0], 1'b1}; nhs++;
      end
    end
    @(negedge clk);
    ar_valid_i = 1'b0; aw_valid_i = 1'b0; w_valid_i = 1'b0;
    chk("arb_count", 64'(nhs), 64'd6);
    chk("arb_order", 64'(seq), 64'b010101);
    guard = 0;
    while (!b_valid_o && guard < 100) begin @(negedge clk); guard++; end
    chk("arb_last_resp_bound", 64'(guard < 100), 64'd1);
    @(negedge clk);

`ifdef AXI_LITE_APB_TIMEOUT_EN
    hold_low = 1'b1;
    en0  = n_en;
    base = n_apb;
    do_read(32'h0001_0000, d, rsp, lat);
    hold_low = 1'b0;
    chk("to_penable_cycles", 64'(n_en - en0), 64'd16);
    chk("to_resp",           64'(rsp), 64'd2);
    chk("to_lat",            64'(lat), 64'd18);
    chk("to_napb",           64'(n_apb - base), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
